fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Controller between the microphone sample stream and the FFT core input. It decimates incoming samples, cuts them into frames of exactly N samples, feeds one frame at a time into the FFT, and blocks further input until the FFT has delivered its last output bin. Samples that arrive while the FFT is busy are discarded and counted. The microphone source is never stalled.

## Interface
- N, 1024: FFT frame length in samples, power of two.
- DW, 16: sample width.
- DECIM_W, 4: width of the decimation control.
- clk  in  1  system clock (18.432 MHz audio/FFT domain).
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run request, sampled only at frame boundaries.
- decim  in  DECIM_W  keep 1 of every decim+1 input samples, latched at frame start.
- in_data  in  DW  microphone sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted.
- fft_data  out  DW  sample to FFT core.
- fft_valid  out  1  FFT input valid.
- fft_ready  in  1  FFT input ready.
- fft_index  out  $clog2(N)  position of the current sample within the frame.
- fft_last  out  1  high with fft_valid when fft_index == N-1.
- out_last  in  1  FFT output handshake on the bin with index N-1 (valid & ready & index==N-1).
- frame_done  out  1  one-cycle pulse when a full frame has completed the FFT.
- busy  out  1  state != IDLE.
- drop_count  out  16  saturating count of kept samples discarded in WAIT.

## Operation
- States: IDLE, FILL, WAIT.
- IDLE: in_ready=1, all input discarded and not counted. If enable=1, go to FILL next cycle, latch decim, clear decim_cnt and fft_index.
- FILL: keep = (decim_cnt == 0). decim_cnt counts 0..decim_l and then wraps to 0. It advances on each in_valid & in_ready.
  - If keep: fft_valid=in_valid, fft_data=in_data, in_ready=fft_ready.
  - If not keep: fft_valid=0, in_ready=1, the sample is discarded.
- Each fft_valid & fft_ready increments fft_index. On the handshake at index N-1, fft_index wraps to 0 and the state goes to WAIT.
- WAIT: in_ready=1, fft_valid=0. Each in_valid beat whose decim_cnt==0 increments drop_count, which saturates at 0xFFFF. decim_cnt keeps running.
- On out_last in WAIT: pulse frame_done next cycle. If enable=1, go to FILL, relatch decim and clear decim_cnt. Otherwise go to IDLE.
- enable falling during FILL has no effect. The frame always completes, so the FFT never sees a partial frame.
- out_last in IDLE or FILL is ignored. This covers a stale pulse, including one coincident with the last FILL handshake.
- drop_count clears only on reset.

## Timing
- Reset values: state IDLE, fft_valid 0, fft_index 0, fft_last 0, frame_done 0, busy 0, drop_count 0, in_ready 1 (IDLE).
- Data path is combinational, with zero latency from in_data to fft_data. fft_valid and in_ready are combinational from state, keep, in_valid and fft_ready.
- fft_valid does not depend on fft_ready, and fft_data is stable while fft_valid & !fft_ready. The source holds until accepted.
- State transitions take one cycle after the triggering handshake. The first FILL beat is the cycle after the IDLE→FILL decision.
- frame_done is registered, asserted the cycle after out_last in WAIT.
- Asynchronous reset mid-frame returns to IDLE immediately. The FFT core is reset by the same reset_n, so no partial-frame recovery is required.

## Structure
- Shared package fft_pkg: N, DW, IDX_W=$clog2(N), and the state enum seq_state_t {IDLE, FILL, WAIT}. The LED/bin display logic also uses N and IDX_W.
- One natural sub-module: sat_counter (width parameter, inc, clear, saturating), used for drop_count.

## Test plan
- Reset then enable=1, decim=0, in_valid continuous, fft_ready=1 → 1024 fft_valid beats, index 0..1023, fft_last on beat 1024, then in_ready=1 and fft_valid=0 (WAIT).
- decim=3, input ramp 0,1,2,… → FFT receives 0,4,8,…,4092, and fft_last accompanies sample 4092.
- fft_ready toggled 50% in FILL → in_ready mirrors fft_ready on kept samples; no sample is lost or duplicated; index is monotonic.
- In WAIT, 300 input beats with decim=1 → drop_count=150; then out_last → frame_done pulse one cycle later and FILL restarts at index 0.
- Deassert enable at index 500 → frame completes to 1023; after out_last the block returns to IDLE and busy=0. An out_last pulse injected during FILL is ignored.
- Preload drop_count near 0xFFFF via a long WAIT → it holds at 0xFFFF. reset_n low mid-FILL → all outputs take reset values asynchronously.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT front end.
// The LED/bin display logic also imports N and IDX_W from here.
package fft_pkg;
  localparam int N       = 1024;
  localparam int DW      = 16;
  localparam int IDX_W   = $clog2(N);
  localparam int DECIM_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } seq_state_t;
endpackage

// File: rtl/fft_frame_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/fft_frame_sequencer.sv
// Decimates the microphone stream, cuts it into N-sample frames for the FFT,
// and discards (and counts) input while the FFT is still draining a frame.
module fft_frame_sequencer #(
  parameter int N       = fft_pkg::N,
  parameter int DW      = fft_pkg::DW,
  parameter int DECIM_W = fft_pkg::DECIM_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DECIM_W-1:0]   decim,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DW-1:0]        fft_data,
  output logic                 fft_valid,
  input  logic                 fft_ready,
  output logic [$clog2(N)-1:0] fft_index,
  output logic                 fft_last,
  input  logic                 out_last,
  output logic                 frame_done,
  output logic                 busy,
  output logic [15:0]          drop_count
);
  import fft_pkg::*;

  localparam int IW = $clog2(N);

  seq_state_t         state_d, state_q;
  logic [DECIM_W-1:0] decim_l_d, decim_l_q;
  logic [DECIM_W-1:0] decim_cnt_d, decim_cnt_q;
  logic [IW-1:0]      idx_d, idx_q;
  logic               frame_done_d, frame_done_q;

  logic               keep;
  logic               in_hs;
  logic               fft_hs;
  logic               drop_inc;
  logic [DECIM_W-1:0] cnt_next;

  always_comb begin
    keep      = (decim_cnt_q == '0);
    fft_valid = (state_q == FILL) && keep && in_valid;
    in_ready  = ((state_q == FILL) && keep) ? fft_ready : 1'b1;
    in_hs     = in_valid && in_ready;
    fft_hs    = fft_valid && fft_ready;
    cnt_next  = (decim_cnt_q == decim_l_q) ? '0 : decim_cnt_q + 1'b1;

    state_d      = state_q;
    decim_l_d    = decim_l_q;
    decim_cnt_d  = decim_cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    drop_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = FILL;
          decim_l_d   = decim;
          decim_cnt_d = '0;
          idx_d       = '0;
        end
      end
      FILL: begin
        if (in_hs) decim_cnt_d = cnt_next;
        if (fft_hs) begin
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (in_valid) begin
          decim_cnt_d = cnt_next;
          drop_inc    = keep;
        end
        // Restart clears the decimation phase so every frame starts on a kept sample.
        if (out_last) begin
          frame_done_d = 1'b1;
          if (enable) begin
            state_d     = FILL;
            decim_l_d   = decim;
            decim_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      decim_l_q    <= '0;
      decim_cnt_q  <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      decim_l_q    <= decim_l_d;
      decim_cnt_q  <= decim_cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop_inc),
    .clear   (1'b0),
    .count   (drop_count)
  );

  assign fft_data   = in_data;
  assign fft_index  = idx_q;
  assign fft_last   = fft_valid && (idx_q == IW'(N - 1));
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: kept samples are queued at drive
// time and popped when the FFT-side handshake occurs.
module tb_fft_frame_sequencer;
  localparam int N       = 1024;
  localparam int DW      = 16;
  localparam int DECIM_W = 4;
  localparam int IW      = 10;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic [DECIM_W-1:0] decim;
  logic [DW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DW-1:0]      fft_data;
  logic               fft_valid;
  logic               fft_ready;
  logic [IW-1:0]      fft_index;
  logic               fft_last;
  logic               out_last;
  logic               frame_done;
  logic               busy;
  logic [15:0]        drop_count;

  always #5 clk = ~clk;

  fft_frame_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .decim      (decim),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fft_data   (fft_data),
    .fft_valid  (fft_valid),
    .fft_ready  (fft_ready),
    .fft_index  (fft_index),
    .fft_last   (fft_last),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy),
    .drop_count (drop_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0=IDLE 1=FILL 2=WAIT
  int          ms, mcnt, mdecim, midx, mdrop;
  bit          mfd;
  bit          hold;
  int          rv;
  int          vmode;   // 0 idle, 1 continuous, 2 random
  int          rmode;   // 1 always ready, 2 random
  int          n_acc;
  logic [DW-1:0] last_data;
  logic [DW-1:0] sbq[$];

  task automatic model_reset();
    ms = 0; mcnt = 0; mdecim = 0; midx = 0; mdrop = 0; mfd = 0; hold = 0;
    sbq.delete();
  endtask

  task automatic drive();
    if (!hold) begin
      case (vmode)
        1:       in_valid = 1'b1;
        2:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b0;
      endcase
      if (in_valid) begin
        in_data = rv[DW-1:0];
        rv++;
        if (ms == 1 && mcnt == 0) sbq.push_back(in_data);
      end
    end
    fft_ready = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic evaluate();
    bit mkeep, e_rdy, e_val;
    logic [DW-1:0] exp_d;
    mkeep = (mcnt == 0);
    e_rdy = (ms == 1 && mkeep) ? fft_ready : 1'b1;
    e_val = (ms == 1) && mkeep && in_valid;
    check_eq("in_ready",   32'(in_ready),   32'(e_rdy));
    check_eq("fft_valid",  32'(fft_valid),  32'(e_val));
    check_eq("busy",       32'(busy),       32'(ms != 0));
    check_eq("frame_done", 32'(frame_done), 32'(mfd));
    check_eq("drop_count", 32'(drop_count), 32'(mdrop));
    check_eq("fft_index",  32'(fft_index),  32'(midx));
    check_eq("fft_last",   32'(fft_last),   32'(e_val && midx == N - 1));
    if (e_val && fft_ready) begin
      if (sbq.size() == 0) begin
        check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        exp_d = sbq.pop_front();
        check_eq("fft_data", 32'(fft_data), 32'(exp_d));
      end
      n_acc++;
      if (midx == N - 1) last_data = fft_data;
    end
    hold = in_valid && !e_rdy;
    mfd = 0;
    case (ms)
      0: if (enable) begin ms = 1; mdecim = int'(decim); mcnt = 0; midx = 0; end
      1: begin
        if (in_valid && e_rdy) mcnt = (mcnt == mdecim) ? 0 : mcnt + 1;
        if (e_val && fft_ready) begin
          if (midx == N - 1) begin midx = 0; ms = 2; end
          else midx++;
        end
      end
      default: begin
        if (in_valid) begin
          if (mkeep && mdrop < 65535) mdrop++;
          mcnt = (mcnt == mdecim) ? 0 : mcnt + 1;
        end
        if (out_last) begin
          mfd = 1;
          if (enable) begin ms = 1; mdecim = int'(decim); mcnt = 0; end
          else ms = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    out_last = 1'b0;
  endtask

  task automatic run_until_state(input int target, input int budget);
    int k = 0;
    while (ms != target && k < budget) begin
      step();
      k++;
    end
    if (ms != target) check_eq("timeout", 32'(ms), 32'(target));
  endtask

  int drop_before;
  int k;

  initial begin
    reset_n = 1'b0; enable = 1'b0; decim = '0; in_valid = 1'b0; in_data = '0;
    fft_ready = 1'b1; out_last = 1'b0; vmode = 0; rmode = 1; rv = 0; n_acc = 0;
    last_data = '0;
    model_reset();
    #12;
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_fft_valid",  32'(fft_valid),  32'd0);
    check_eq("rst_in_ready",   32'(in_ready),   32'd1);
    check_eq("rst_fft_index",  32'(fft_index),  32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full frame, decim=0, continuous input
    enable = 1'b1; decim = 4'd0;
    step();
    rv = 0; vmode = 1; n_acc = 0;
    run_until_state(2, 3000);
    check_eq("frame1_beats", 32'(n_acc), 32'd1024);
    vmode = 0;
    step(); step();
    enable = 1'b0; out_last = 1'b1;
    step();
    step();

    // decim=3 ramp: FFT sees 0,4,...,4092
    enable = 1'b1; decim = 4'd3;
    step();
    rv = 0; vmode = 1; n_acc = 0;
    run_until_state(2, 6000);
    check_eq("decim3_beats", 32'(n_acc), 32'd1024);
    check_eq("decim3_last",  32'(last_data), 32'd4092);
    vmode = 0;
    step();

    // Restart from WAIT with decim=1 and a random fft_ready
    decim = 4'd1; out_last = 1'b1;
    step();
    vmode = 1; rmode = 2; n_acc = 0;
    run_until_state(2, 8000);
    check_eq("rand_beats", 32'(n_acc), 32'd1024);
    rmode = 1;
    drop_before = int'(drop_count);
    for (int i = 0; i < 300; i++) step();
    vmode = 0;
    step();
    check_eq("drop_150", 32'(int'(drop_count) - drop_before), 32'd150);

    // enable drops at index 500; stray out_last in FILL is ignored
    decim = 4'd0; out_last = 1'b1;
    step();
    vmode = 1; n_acc = 0;
    k = 0;
    while (ms != 2 && k < 3000) begin
      if (midx == 500) enable = 1'b0;
      out_last = (midx == 200) || (midx == N - 1);
      step();
      k++;
    end
    if (ms != 2) check_eq("timeout_en", 32'(ms), 32'd2);
    check_eq("en_drop_beats", 32'(n_acc), 32'd1024);
    vmode = 0;
    step();
    out_last = 1'b1;
    step();
    step();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Long WAIT drives drop_count into saturation
    enable = 1'b1; decim = 4'd0;
    step();
    vmode = 1;
    run_until_state(2, 3000);
    k = 0;
    while (mdrop < 65535 && k < 70000) begin step(); k++; end
    for (int i = 0; i < 40; i++) step();
    check_eq("drop_sat", 32'(drop_count), 32'd65535);

    // Back into FILL, then asynchronous reset mid-frame
    vmode = 0; out_last = 1'b1;
    step();
    vmode = 1;
    for (int i = 0; i < 20; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy",       32'(busy),       32'd0);
    check_eq("arst_fft_valid",  32'(fft_valid),  32'd0);
    check_eq("arst_in_ready",   32'(in_ready),   32'd1);
    check_eq("arst_fft_index",  32'(fft_index),  32'd0);
    check_eq("arst_fft_last",   32'(fft_last),   32'd0);
    check_eq("arst_frame_done", 32'(frame_done), 32'd0);
    check_eq("arst_drop_count", 32'(drop_count), 32'd0);
    model_reset();
    enable = 1'b0; vmode = 0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
